// File: rtl/sos_cascade_fg_prog_seq.sv
// Closed-loop floating-gate programming sequencer for a cascade of SOS sections.
// It selects each bias cell, fires bursts of injection pulses, and measures the cell until it reaches its target.
module sos_cascade_fg_prog_seq #(
  parameter int NUM_STAGES      = 5,
  parameter int NUM_CELLS       = 4 * NUM_STAGES,
  parameter int AW              = $clog2(NUM_CELLS),
  parameter int MW              = 12,
  parameter int PULSE_CYC       = 16,
  parameter int SETTLE_CYC      = 4,
  parameter int PULSES_PER_MEAS = 4,
  parameter int MAX_PULSES      = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_sweep,
  input  logic [AW-1:0] cmd_addr,
  input  logic [MW-1:0] cmd_target,
  output logic [AW-1:0] dec_addr,
  output logic          drain_sel,
  output logic          vsel_n,
  output logic          inj_pulse,
  output logic          meas_req,
  input  logic          meas_ack,
  input  logic [MW-1:0] meas_data,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status,
  output logic [AW:0]   cells_done
);

  localparam int MAXC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = $clog2(MAX_PULSES + PULSES_PER_MEAS + 1);
  localparam int BW   = $clog2(PULSES_PER_MEAS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_PULSE, S_GAP, S_MEAS, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t        state;
  logic          sweep;
  logic [MW-1:0] target;
  logic [MW-1:0] meas_val;
  logic [CW-1:0] cyc_cnt;
  logic [PW-1:0] pulse_cnt;
  logic [BW-1:0] burst_cnt;
  logic          timeout;

  assign busy = ~cmd_ready;

  // The async reset clears every select and pulse output, so a reset never stretches an injection pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b1;
      dec_addr   <= '0;
      drain_sel  <= 1'b0;
      vsel_n     <= 1'b1;
      inj_pulse  <= 1'b0;
      meas_req   <= 1'b0;
      done       <= 1'b0;
      status     <= 2'b00;
      cells_done <= '0;
      sweep      <= 1'b0;
      target     <= '0;
      meas_val   <= '0;
      cyc_cnt    <= '0;
      pulse_cnt  <= '0;
      burst_cnt  <= '0;
      timeout    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            sweep      <= cmd_sweep;
            target     <= cmd_target;
            status     <= 2'b00;
            cells_done <= '0;
            timeout    <= 1'b0;
            pulse_cnt  <= '0;
            burst_cnt  <= '0;
            cyc_cnt    <= '0;
            cmd_ready  <= 1'b0;
            if ({1'b0, cmd_addr} >= (AW+1)'(NUM_CELLS)) begin
              status <= 2'b10;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              dec_addr  <= cmd_addr;
              drain_sel <= 1'b1;
              vsel_n    <= 1'b0;
              state     <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          if (cyc_cnt == CW'(SETTLE_CYC - 1)) begin
            cyc_cnt   <= '0;
            inj_pulse <= 1'b1;
            pulse_cnt <= pulse_cnt + PW'(1);
            burst_cnt <= burst_cnt + BW'(1);
            state     <= S_PULSE;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        S_PULSE: begin
          if (cyc_cnt == CW'(PULSE_CYC - 1)) begin
            cyc_cnt   <= '0;
            inj_pulse <= 1'b0;
            state     <= S_GAP;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (cyc_cnt == CW'(SETTLE_CYC - 1)) begin
            cyc_cnt <= '0;
            if (burst_cnt == BW'(PULSES_PER_MEAS)) begin
              burst_cnt <= '0;
              meas_req  <= 1'b1;
              state     <= S_MEAS;
            end else begin
              inj_pulse <= 1'b1;
              pulse_cnt <= pulse_cnt + PW'(1);
              burst_cnt <= burst_cnt + BW'(1);
              state     <= S_PULSE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        S_MEAS: begin
          if (meas_ack) begin
            meas_val <= meas_data;
            meas_req <= 1'b0;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          // A cell that reached its target counts as ok even if it also used its whole pulse budget.
          if (meas_val >= target || pulse_cnt >= PW'(MAX_PULSES)) begin
            if (meas_val < target) timeout <= 1'b1;
            drain_sel  <= 1'b0;
            vsel_n     <= 1'b1;
            cells_done <= cells_done + (AW+1)'(1);
            state      <= S_NEXT;
          end else begin
            inj_pulse <= 1'b1;
            pulse_cnt <= pulse_cnt + PW'(1);
            burst_cnt <= burst_cnt + BW'(1);
            state     <= S_PULSE;
          end
        end
        S_NEXT: begin
          if (sweep && dec_addr < AW'(NUM_CELLS - 1)) begin
            dec_addr  <= dec_addr + AW'(1);
            pulse_cnt <= '0;
            burst_cnt <= '0;
            cyc_cnt   <= '0;
            drain_sel <= 1'b1;
            vsel_n    <= 1'b0;
            state     <= S_SELECT;
          end else begin
            done   <= 1'b1;
            status <= {1'b0, timeout};
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sos_cascade_fg_prog_seq.sv
// Randomised bench for sos_cascade_fg_prog_seq: it uses a measurement responder and a per-cell model that predicts
// pulse and measurement counts, status and cells_done.
module tb_sos_cascade_fg_prog_seq;

  localparam int NUM_STAGES = 5;
  localparam int NC         = 4 * NUM_STAGES;
  localparam int AW         = $clog2(NC);
  localparam int MW         = 12;
  localparam int PULSE_CYC  = 4;
  localparam int SETTLE_CYC = 3;
  localparam int PPM        = 4;
  localparam int MAX_P      = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_sweep = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [MW-1:0] cmd_target = '0;
  logic [AW-1:0] dec_addr;
  logic          drain_sel;
  logic          vsel_n;
  logic          inj_pulse;
  logic          meas_req;
  logic          meas_ack = 1'b0;
  logic [MW-1:0] meas_data = '0;
  logic          busy;
  logic          done;
  logic [1:0]    status;
  logic [AW:0]   cells_done;

  int checks = 0;
  int errors = 0;

  int pulses_seen [32];
  int meas_seen   [32];
  int cur_step   = 0;
  int resp_delay = 0;
  bit stray_en   = 0;
  bit sel_seen   = 0;
  int max_addr   = 0;
  int hi_cnt     = 0;
  int req_cnt    = 0;
  int wait_cnt   = 0;
  bit inj_prev   = 0;
  bit req_prev   = 0;

  sos_cascade_fg_prog_seq #(
    .NUM_STAGES(NUM_STAGES), .MW(MW), .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC),
    .PULSES_PER_MEAS(PPM), .MAX_PULSES(MAX_P)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sweep(cmd_sweep),
    .cmd_addr(cmd_addr), .cmd_target(cmd_target), .dec_addr(dec_addr), .drain_sel(drain_sel),
    .vsel_n(vsel_n), .inj_pulse(inj_pulse), .meas_req(meas_req), .meas_ack(meas_ack),
    .meas_data(meas_data), .busy(busy), .done(done), .status(status), .cells_done(cells_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // The cell's measured value rises by one step per measurement, and the cell finishes on reaching its target or its pulse budget.
  function automatic void predictCell(input int target, input int step,
                                      output int pulses, output int meas, output bit tmo);
    int v;
    pulses = 0; meas = 0; tmo = 0;
    for (int k = 1; k <= 1000; k++) begin
      v = k * step;
      if (v > 4095) v = 4095;
      if (v >= target) begin pulses = k * PPM; meas = k; return; end
      if (k * PPM >= MAX_P) begin pulses = k * PPM; meas = k; tmo = 1; return; end
    end
  endfunction

  // Measurement responder: it answers meas_req after resp_delay cycles and can also fire stray acks while a pulse is active.
  always @(negedge clk) begin
    int v;
    if (!rst_n) begin
      meas_ack = 1'b0;
      wait_cnt = 0;
    end else if (meas_req) begin
      if (wait_cnt >= resp_delay) begin
        meas_seen[dec_addr]++;
        v = meas_seen[dec_addr] * cur_step;
        if (v > 4095) v = 4095;
        meas_data = MW'(v);
        meas_ack  = 1'b1;
        wait_cnt  = 0;
      end else begin
        meas_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (stray_en && inj_pulse && $urandom_range(0, 2) == 0) begin
        meas_ack  = 1'b1;
        meas_data = 12'hFFF;
      end else begin
        meas_ack = 1'b0;
      end
    end
  end

  // Monitor: it counts pulses per cell and checks the pulse width, the select invariant and the length of each meas_req.
  always @(negedge clk) begin
    if (!rst_n) begin
      hi_cnt = 0; req_cnt = 0; inj_prev = 0; req_prev = 0;
    end else begin
      if (inj_pulse) begin
        if (!inj_prev) pulses_seen[dec_addr]++;
        hi_cnt++;
        checkOutput("inj_implies_sel", {30'd0, drain_sel, vsel_n}, 2);
      end else if (inj_prev) begin
        checkOutput("pulse_width", hi_cnt, PULSE_CYC);
        hi_cnt = 0;
      end
      inj_prev = inj_pulse;
      if (drain_sel || inj_pulse) sel_seen = 1;
      if (drain_sel && int'(dec_addr) > max_addr) max_addr = int'(dec_addr);
      if (meas_req) req_cnt++;
      else if (req_prev) begin
        checkOutput("meas_req_len", req_cnt, resp_delay + 1);
        req_cnt = 0;
      end
      req_prev = meas_req;
    end
  end

  task automatic applyStimulus(input bit sweep, input int addr, input int target, input int step,
                               input int delay, input bit stray);
    int edges, first_inj, last, exp_p, exp_m, exp_status;
    bit seen, tmo, tmo_any;
    for (int i = 0; i < 32; i++) begin pulses_seen[i] = 0; meas_seen[i] = 0; end
    sel_seen = 0; max_addr = 0; cur_step = step; resp_delay = delay; stray_en = stray;
    @(negedge clk);
    checkOutput("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_sweep = sweep; cmd_addr = AW'(addr); cmd_target = MW'(target);
    edges = 0; first_inj = 0; seen = 0;
    while (!seen && edges < 20000) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) cmd_valid = 1'b0;
      if (edges == 10 && busy) begin cmd_valid = 1'b1; cmd_addr = '0; cmd_sweep = 1'b1; end
      if (edges == 11) cmd_valid = 1'b0;
      if (inj_pulse && first_inj == 0) first_inj = edges;
      if (done) seen = 1;
    end
    checkOutput("done_seen", seen, 1);
    if (addr >= NC) begin
      exp_status = 2;
      checkOutput("bad_addr_latency", edges, 1);
      checkOutput("bad_addr_cells", cells_done, 0);
      checkOutput("bad_addr_no_select", sel_seen, 0);
    end else begin
      last = sweep ? NC - 1 : addr;
      tmo_any = 0;
      checkOutput("first_pulse_latency", first_inj, SETTLE_CYC + 1);
      for (int c = 0; c < NC; c++) begin
        exp_p = 0; exp_m = 0; tmo = 0;
        if (c >= addr && c <= last) predictCell(target, step, exp_p, exp_m, tmo);
        tmo_any |= tmo;
        checkOutput($sformatf("pulses_cell%0d", c), pulses_seen[c], exp_p);
        checkOutput($sformatf("meas_cell%0d", c), meas_seen[c], exp_m);
      end
      exp_status = tmo_any ? 1 : 0;
      checkOutput("cells_done", cells_done, last - addr + 1);
      checkOutput("max_dec_addr", max_addr, last);
    end
    checkOutput("status", status, exp_status);
    @(posedge clk); #1;
    checkOutput("done_one_cycle", done, 0);
    checkOutput("ready_after_done", cmd_ready, 1);
    checkOutput("status_held", status, exp_status);
  endtask

  task automatic resetDuring(input bit in_meas);
    int w;
    for (int i = 0; i < 32; i++) begin pulses_seen[i] = 0; meas_seen[i] = 0; end
    cur_step = 0; resp_delay = 50; stray_en = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sweep = 1'b0; cmd_addr = AW'(5); cmd_target = 12'hFFF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    w = 0;
    while (!(in_meas ? meas_req : inj_pulse) && w < 400) begin @(posedge clk); #1; w++; end
    checkOutput(in_meas ? "rst_reach_meas" : "rst_reach_pulse", in_meas ? meas_req : inj_pulse, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_inj_low", inj_pulse, 0);
    checkOutput("rst_drain_low", drain_sel, 0);
    checkOutput("rst_meas_req_low", meas_req, 0);
    checkOutput("rst_vsel_n_high", vsel_n, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_ready_after", cmd_ready, 1);
    checkOutput("rst_busy_after", busy, 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a;
    repeat (3) @(negedge clk);
    checkOutput("reset_cmd_ready", cmd_ready, 1);
    checkOutput("reset_vsel_n", vsel_n, 1);
    checkOutput("reset_drain_sel", drain_sel, 0);
    checkOutput("reset_inj_pulse", inj_pulse, 0);
    checkOutput("reset_meas_req", meas_req, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_status", status, 0);
    checkOutput("reset_cells_done", cells_done, 0);
    checkOutput("reset_dec_addr", dec_addr, 0);
    rst_n = 1'b1;

    applyStimulus(0, 3, 100, 40, 1, 0);
    applyStimulus(1, 18, 0, 7, 0, 1);
    applyStimulus(0, 6, 4095, 0, 2, 0);
    applyStimulus(1, 18, 4095, 0, 0, 1);
    applyStimulus(0, 20, 50, 10, 0, 0);
    applyStimulus(1, 31, 50, 10, 0, 0);
    applyStimulus(0, 11, 2000, 900, 50, 1);
    applyStimulus(0, 19, 4095, 4095, 0, 0);

    resetDuring(0);
    applyStimulus(0, 9, 300, 100, 2, 1);
    resetDuring(1);
    applyStimulus(1, 17, 1500, 600, 3, 0);

    for (int i = 0; i < 8; i++) begin
      a = (i == 3) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 19));
      if (i % 2 == 1 && a < 15) a = 15 + int'($urandom_range(0, 4));
      applyStimulus(bit'(i % 2), a, int'($urandom_range(0, 4095)), int'($urandom_range(0, 1200)),
                    int'($urandom_range(0, 6)), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
